// File: rtl/sce_axi_pkg.sv
// Shared types for the SCE AXI quiesce unit: quiesce FSM states and AXI response codes.
package sce_axi_pkg;
    typedef enum logic [1:0] {
        Q_IDLE  = 2'd0,
        Q_DRAIN = 2'd1,
        Q_HOLD  = 2'd2
    } qstate_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
endpackage

// File: rtl/soc_axi_quiesce_if.sv
// NCH-wide AXI4 bundle; every field is a packed per-channel vector.
interface soc_axi_quiesce_if #(
    parameter int NCH = 2,
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int IDW = 4
);
    logic [NCH-1:0]              awvalid, awready;
    logic [NCH-1:0][IDW-1:0]     awid;
    logic [NCH-1:0][AW-1:0]      awaddr;
    logic [NCH-1:0][2:0]         awsize, awprot;
    logic [NCH-1:0][7:0]         awlen;
    logic [NCH-1:0][1:0]         awburst;
    logic [NCH-1:0]              wvalid, wready, wlast;
    logic [NCH-1:0][DW-1:0]      wdata;
    logic [NCH-1:0][DW/8-1:0]    wstrb;
    logic [NCH-1:0]              bvalid, bready;
    logic [NCH-1:0][IDW-1:0]     bid;
    logic [NCH-1:0][1:0]         bresp;
    logic [NCH-1:0]              arvalid, arready;
    logic [NCH-1:0][IDW-1:0]     arid;
    logic [NCH-1:0][AW-1:0]      araddr;
    logic [NCH-1:0][2:0]         arsize, arprot;
    logic [NCH-1:0][7:0]         arlen;
    logic [NCH-1:0][1:0]         arburst;
    logic [NCH-1:0]              rvalid, rready, rlast;
    logic [NCH-1:0][IDW-1:0]     rid;
    logic [NCH-1:0][DW-1:0]      rdata;
    logic [NCH-1:0][1:0]         rresp;

    modport master (
        output awvalid, awid, awaddr, awsize, awprot, awlen, awburst, input awready,
        output wvalid, wdata, wstrb, wlast, input wready,
        input  bvalid, bid, bresp, output bready,
        output arvalid, arid, araddr, arsize, arprot, arlen, arburst, input arready,
        input  rvalid, rid, rdata, rresp, rlast, output rready
    );

    modport slave (
        input  awvalid, awid, awaddr, awsize, awprot, awlen, awburst, output awready,
        input  wvalid, wdata, wstrb, wlast, output wready,
        output bvalid, bid, bresp, input bready,
        input  arvalid, arid, araddr, arsize, arprot, arlen, arburst, output arready,
        output rvalid, rid, rdata, rresp, rlast, input rready
    );
endinterface

// File: rtl/soc_axi_ost_ctr.sv
// Per-channel outstanding tracking: counters, issue gating with valid-hold, and sticky
// error for responses that match nothing outstanding.
module soc_axi_ost_ctr #(
    parameter int OSTW = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            blk,
    input  logic [OSTW-1:0] ost_max,
    input  logic            err_clr,
    input  logic            s_awvalid,
    input  logic            m_awready,
    output logic            m_awvalid,
    output logic            s_awready,
    input  logic            s_wvalid,
    input  logic            s_wlast,
    input  logic            m_wready,
    output logic            m_wvalid,
    output logic            s_wready,
    input  logic            m_bvalid,
    input  logic            s_bready,
    input  logic            s_arvalid,
    input  logic            m_arready,
    output logic            m_arvalid,
    output logic            s_arready,
    input  logic            m_rvalid,
    input  logic            m_rlast,
    input  logic            s_rready,
    output logic            busy,
    output logic            idle,
    output logic            err
);
    localparam logic [OSTW-1:0] CNT_MAX = '1;

    logic [OSTW-1:0] wr_ost_q, wr_ost_d, wpend_q, wpend_d, rd_ost_q, rd_ost_d;
    logic            aw_hold_q, aw_hold_d, w_hold_q, w_hold_d, ar_hold_q, ar_hold_d;
    logic            err_q, err_d;
    logic            aw_pass, w_pass, ar_pass;
    logic            aw_hs, w_last_hs, b_hs, ar_hs, r_last_hs, b_spur, r_spur;

    always_comb begin
        // A beat already presented downstream keeps passing until accepted, even if gating closes.
        aw_pass   = (!blk && (wr_ost_q < ost_max) && (wpend_q != CNT_MAX)) || aw_hold_q;
        w_pass    = (wpend_q != '0) || w_hold_q;
        ar_pass   = (!blk && (rd_ost_q < ost_max)) || ar_hold_q;

        m_awvalid = s_awvalid && aw_pass;
        s_awready = m_awready && aw_pass;
        m_wvalid  = s_wvalid && w_pass;
        s_wready  = m_wready && w_pass;
        m_arvalid = s_arvalid && ar_pass;
        s_arready = m_arready && ar_pass;

        aw_hs     = m_awvalid && m_awready;
        w_last_hs = m_wvalid && m_wready && s_wlast;
        b_hs      = m_bvalid && s_bready;
        ar_hs     = m_arvalid && m_arready;
        r_last_hs = m_rvalid && s_rready && m_rlast;
        b_spur    = b_hs && (wr_ost_q == '0);
        r_spur    = r_last_hs && (rd_ost_q == '0);

        wr_ost_d  = wr_ost_q + OSTW'(aw_hs) - OSTW'(b_hs && !b_spur);
        wpend_d   = wpend_q + OSTW'(aw_hs) - OSTW'(w_last_hs && (wpend_q != '0));
        rd_ost_d  = rd_ost_q + OSTW'(ar_hs) - OSTW'(r_last_hs && !r_spur);

        aw_hold_d = m_awvalid && !m_awready;
        w_hold_d  = m_wvalid && !m_wready;
        ar_hold_d = m_arvalid && !m_arready;

        err_d     = (err_q && !err_clr) || b_spur || r_spur;

        busy      = (wr_ost_q != '0) || (wpend_q != '0) || (rd_ost_q != '0);
        idle      = !busy && !aw_hold_q && !w_hold_q && !ar_hold_q;
        err       = err_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ost_q  <= '0;
            wpend_q   <= '0;
            rd_ost_q  <= '0;
            aw_hold_q <= 1'b0;
            w_hold_q  <= 1'b0;
            ar_hold_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_ost_q  <= wr_ost_d;
            wpend_q   <= wpend_d;
            rd_ost_q  <= rd_ost_d;
            aw_hold_q <= aw_hold_d;
            w_hold_q  <= w_hold_d;
            ar_hold_q <= ar_hold_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: rtl/soc_axi_quiesce.sv
// AXI4 master-side quiesce and outstanding-limit unit: per-channel trackers plus the
// drain/hold FSM that produces quiesce_ack.
module soc_axi_quiesce
    import sce_axi_pkg::*;
#(
    parameter int NCH  = 2,
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int IDW  = 4,
    parameter int OSTW = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [OSTW-1:0]     ost_max,
    input  logic                quiesce_req,
    output logic                quiesce_ack,
    output logic [NCH-1:0]      busy,
    output logic [NCH-1:0]      err,
    input  logic                err_clr,
    soc_axi_quiesce_if.slave    s,
    soc_axi_quiesce_if.master   m
);
    qstate_e                state_q, state_d;
    logic                   quiesce_ack_q, quiesce_ack_d;
    logic                   blk;
    logic [NCH-1:0]         idle_w;
    logic [NCH-1:0]         m_awvalid_w, s_awready_w, m_wvalid_w, s_wready_w, m_arvalid_w, s_arready_w;
    logic [NCH-1:0][AW-1:0] awaddr_w, araddr_w;
    logic [NCH-1:0][DW-1:0] wdata_w;
    logic [NCH-1:0][IDW-1:0] awid_w;

    // Address/data/id routed through top-parameter-typed wires so an interface of the wrong shape is caught by width checks.
    assign awaddr_w  = s.awaddr;
    assign araddr_w  = s.araddr;
    assign wdata_w   = s.wdata;
    assign awid_w    = s.awid;

    assign m.awid    = awid_w;
    assign m.awaddr  = awaddr_w;
    assign m.awsize  = s.awsize;
    assign m.awprot  = s.awprot;
    assign m.awlen   = s.awlen;
    assign m.awburst = s.awburst;
    assign m.awvalid = m_awvalid_w;
    assign s.awready = s_awready_w;
    assign m.wdata   = wdata_w;
    assign m.wstrb   = s.wstrb;
    assign m.wlast   = s.wlast;
    assign m.wvalid  = m_wvalid_w;
    assign s.wready  = s_wready_w;
    assign s.bvalid  = m.bvalid;
    assign s.bid     = m.bid;
    assign s.bresp   = m.bresp;
    assign m.bready  = s.bready;
    assign m.arid    = s.arid;
    assign m.araddr  = araddr_w;
    assign m.arsize  = s.arsize;
    assign m.arprot  = s.arprot;
    assign m.arlen   = s.arlen;
    assign m.arburst = s.arburst;
    assign m.arvalid = m_arvalid_w;
    assign s.arready = s_arready_w;
    assign s.rvalid  = m.rvalid;
    assign s.rid     = m.rid;
    assign s.rdata   = m.rdata;
    assign s.rresp   = m.rresp;
    assign s.rlast   = m.rlast;
    assign m.rready  = s.rready;

    assign blk         = (state_q != Q_IDLE);
    assign quiesce_ack = quiesce_ack_q;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        soc_axi_ost_ctr #(.OSTW(OSTW)) u_ctr (
            .clk       (clk),
            .resetn    (resetn),
            .blk       (blk),
            .ost_max   (ost_max),
            .err_clr   (err_clr),
            .s_awvalid (s.awvalid[gi]),
            .m_awready (m.awready[gi]),
            .m_awvalid (m_awvalid_w[gi]),
            .s_awready (s_awready_w[gi]),
            .s_wvalid  (s.wvalid[gi]),
            .s_wlast   (s.wlast[gi]),
            .m_wready  (m.wready[gi]),
            .m_wvalid  (m_wvalid_w[gi]),
            .s_wready  (s_wready_w[gi]),
            .m_bvalid  (m.bvalid[gi]),
            .s_bready  (s.bready[gi]),
            .s_arvalid (s.arvalid[gi]),
            .m_arready (m.arready[gi]),
            .m_arvalid (m_arvalid_w[gi]),
            .s_arready (s_arready_w[gi]),
            .m_rvalid  (m.rvalid[gi]),
            .m_rlast   (m.rlast[gi]),
            .s_rready  (s.rready[gi]),
            .busy      (busy[gi]),
            .idle      (idle_w[gi]),
            .err       (err[gi])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            Q_IDLE:  if (quiesce_req) state_d = Q_DRAIN;
            Q_DRAIN: if (!quiesce_req) state_d = Q_IDLE;
                     else if (&idle_w) state_d = Q_HOLD;
            Q_HOLD:  if (!quiesce_req) state_d = Q_IDLE;
            default: state_d = Q_IDLE;
        endcase
        quiesce_ack_d = (state_d == Q_HOLD);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= Q_IDLE;
            quiesce_ack_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            quiesce_ack_q <= quiesce_ack_d;
        end
    end
endmodule

// File: tb/tb_soc_axi_quiesce.sv
// Directed bench for soc_axi_quiesce: AR/AW/B scoreboard queues checked at the DUT boundary plus per-step checks.
module tb_soc_axi_quiesce;
    import sce_axi_pkg::*;

    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           resetn;
    logic [3:0]     ost_max;
    logic           quiesce_req;
    logic           quiesce_ack;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] err;
    logic           err_clr;

    int checks = 0;
    int failures = 0;

    logic [63:0] aw_q[$];
    logic [63:0] ar_q[$];
    logic [63:0] b_q[$];
    logic [63:0] mon_exp;

    soc_axi_quiesce_if #(.NCH(NCH), .AW(32), .DW(32), .IDW(4)) s_if ();
    soc_axi_quiesce_if #(.NCH(NCH), .AW(32), .DW(32), .IDW(4)) m_if ();

    soc_axi_quiesce #(.NCH(NCH), .AW(32), .DW(32), .IDW(4), .OSTW(4)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .ost_max     (ost_max),
        .quiesce_req (quiesce_req),
        .quiesce_ack (quiesce_ack),
        .busy        (busy),
        .err         (err),
        .err_clr     (err_clr),
        .s           (s_if),
        .m           (m_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    function automatic logic [63:0] mk_a(input int ch, input logic [31:0] addr);
        return {32'(ch), addr};
    endfunction

    function automatic logic [63:0] mk_b(input int ch, input logic [3:0] id, input logic [1:0] resp);
        return {32'(ch), 16'd0, 8'(id), 8'(resp)};
    endfunction

    // Scoreboard: every downstream AW/AR and upstream B handshake must match the next expected entry.
    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (m_if.awvalid[c] && m_if.awready[c]) begin
                if (aw_q.size() == 0) chk("aw_unexpected", 64'(aw_q.size()), 64'd1);
                else begin
                    mon_exp = aw_q.pop_front();
                    chk("aw_ch_addr", mk_a(c, m_if.awaddr[c]), mon_exp);
                end
            end
            if (m_if.arvalid[c] && m_if.arready[c]) begin
                if (ar_q.size() == 0) chk("ar_unexpected", 64'(ar_q.size()), 64'd1);
                else begin
                    mon_exp = ar_q.pop_front();
                    chk("ar_ch_addr", mk_a(c, m_if.araddr[c]), mon_exp);
                end
            end
            if (s_if.bvalid[c] && s_if.bready[c]) begin
                if (b_q.size() == 0) chk("b_unexpected", 64'(b_q.size()), 64'd1);
                else begin
                    mon_exp = b_q.pop_front();
                    chk("b_ch_id_resp", mk_b(c, s_if.bid[c], s_if.bresp[c]), mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; ost_max = 4'd2; quiesce_req = 1'b0; err_clr = 1'b0;
        s_if.awvalid = '0; s_if.awid = '0; s_if.awaddr = '0; s_if.awsize = '0; s_if.awprot = '0;
        s_if.awlen = '0; s_if.awburst = '0; s_if.wvalid = '0; s_if.wdata = '0; s_if.wstrb = '1;
        s_if.wlast = '0; s_if.bready = '1; s_if.arvalid = '0; s_if.arid = '0; s_if.araddr = '0;
        s_if.arsize = '0; s_if.arprot = '0; s_if.arlen = '0; s_if.arburst = '0; s_if.rready = '1;
        m_if.awready = '1; m_if.wready = '1; m_if.bvalid = '0; m_if.bid = '0; m_if.bresp = '0;
        m_if.arready = '1; m_if.rvalid = '0; m_if.rid = '0; m_if.rdata = '0; m_if.rresp = '0;
        m_if.rlast = '0;

        // Reset values
        neg();
        chk("rst_ack", quiesce_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        tick(); tick();
        resetn = 1'b1;
        tick();

        // 1: outstanding read limit of 2
        s_if.arvalid[0] = 1'b1; s_if.araddr[0] = 32'h100; ar_q.push_back(mk_a(0, 32'h100));
        neg(); chk("t1_ar1_fwd", m_if.arvalid[0], 1);
        tick();
        s_if.araddr[0] = 32'h104; ar_q.push_back(mk_a(0, 32'h104));
        neg(); chk("t1_ar2_fwd", m_if.arvalid[0], 1);
        tick();
        s_if.araddr[0] = 32'h108; ar_q.push_back(mk_a(0, 32'h108));
        neg(); chk("t1_ar3_masked", m_if.arvalid[0], 0);
        chk("t1_ar3_noready", s_if.arready[0], 0);
        tick();
        m_if.rvalid[0] = 1'b1; m_if.rlast[0] = 1'b1; m_if.rdata[0] = 32'hCAFE0001;
        neg(); chk("t1_rvalid_pass", s_if.rvalid[0], 1);
        chk("t1_rdata_pass", s_if.rdata[0], 32'hCAFE0001);
        chk("t1_ar3_still_masked", m_if.arvalid[0], 0);
        chk("t1_busy", busy, 4'b0001);
        tick();
        m_if.rvalid[0] = 1'b0;
        neg(); chk("t1_ar3_issues", m_if.arvalid[0], 1);
        tick();
        s_if.arvalid[0] = 1'b0;
        m_if.rvalid[0] = 1'b1;
        tick(); tick();
        m_if.rvalid[0] = 1'b0; m_if.rlast[0] = 1'b0;
        neg(); chk("t1_drained", busy, 0);
        tick();

        // 2: quiesce across an in-flight write burst
        s_if.awvalid[0] = 1'b1; s_if.awaddr[0] = 32'h200; s_if.awlen[0] = 8'd3;
        aw_q.push_back(mk_a(0, 32'h200));
        neg(); chk("t2_awlen_pass", m_if.awlen[0], 3);
        tick();
        s_if.awvalid[0] = 1'b0; quiesce_req = 1'b1;
        tick();
        s_if.awvalid[1] = 1'b1; s_if.awaddr[1] = 32'h300; aw_q.push_back(mk_a(1, 32'h300));
        neg(); chk("t2_aw_blocked_drain", m_if.awvalid[1], 0);
        chk("t2_ack_drain", quiesce_ack, 0);
        for (int b = 0; b < 4; b++) begin
            tick();
            s_if.wvalid[0] = 1'b1; s_if.wdata[0] = 32'hD000_0000 + 32'(b); s_if.wlast[0] = (b == 3);
            neg(); chk("t2_wdata_pass", m_if.wdata[0], 32'hD000_0000 + 32'(b));
            chk("t2_wvalid_pass", m_if.wvalid[0], 1);
        end
        tick();
        s_if.wvalid[0] = 1'b0; s_if.wlast[0] = 1'b0;
        m_if.bvalid[0] = 1'b1; m_if.bid[0] = 4'h5; m_if.bresp[0] = OKAY;
        b_q.push_back(mk_b(0, 4'h5, OKAY));
        neg(); chk("t2_ack_before_b", quiesce_ack, 0);
        tick();
        m_if.bvalid[0] = 1'b0;
        neg(); chk("t2_ack_b_cycle", quiesce_ack, 0);
        tick();
        neg(); chk("t2_ack_rises", quiesce_ack, 1);
        chk("t2_aw_blocked_hold", m_if.awvalid[1], 0);
        tick();
        quiesce_req = 1'b0;
        tick();
        neg(); chk("t2_ack_falls", quiesce_ack, 0);
        chk("t2_aw_released", m_if.awvalid[1], 1);
        tick();
        s_if.awvalid[1] = 1'b0;
        s_if.wvalid[1] = 1'b1; s_if.wlast[1] = 1'b1; s_if.wdata[1] = 32'hD100_0000;
        tick();
        s_if.wvalid[1] = 1'b0; s_if.wlast[1] = 1'b0;
        m_if.bvalid[1] = 1'b1; m_if.bid[1] = 4'h6; m_if.bresp[1] = OKAY;
        b_q.push_back(mk_b(1, 4'h6, OKAY));
        tick();
        m_if.bvalid[1] = 1'b0;
        neg(); chk("t2_drained", busy, 0);
        tick();

        // 3: forwarded AR held through quiesce until accepted
        m_if.arready[0] = 1'b0;
        s_if.arvalid[0] = 1'b1; s_if.araddr[0] = 32'h400; ar_q.push_back(mk_a(0, 32'h400));
        neg(); chk("t3_ar_fwd", m_if.arvalid[0], 1);
        tick();
        quiesce_req = 1'b1;
        tick();
        neg(); chk("t3_ar_held", m_if.arvalid[0], 1);
        chk("t3_ack_drain", quiesce_ack, 0);
        tick();
        m_if.arready[0] = 1'b1;
        neg(); chk("t3_ar_held_accept", m_if.arvalid[0], 1);
        tick();
        s_if.arvalid[0] = 1'b0;
        neg(); chk("t3_ack_rd_pending", quiesce_ack, 0);
        tick();
        m_if.rvalid[0] = 1'b1; m_if.rlast[0] = 1'b1;
        tick();
        m_if.rvalid[0] = 1'b0; m_if.rlast[0] = 1'b0;
        neg(); chk("t3_ack_r_cycle", quiesce_ack, 0);
        tick();
        neg(); chk("t3_ack_rises", quiesce_ack, 1);
        tick();
        quiesce_req = 1'b0;
        tick();
        neg(); chk("t3_ack_falls", quiesce_ack, 0);
        tick();

        // 4: spurious B sets sticky err; set wins over clear
        m_if.bvalid[1] = 1'b1; m_if.bid[1] = 4'h9; m_if.bresp[1] = SLVERR;
        b_q.push_back(mk_b(1, 4'h9, SLVERR));
        neg(); chk("t4_err_before", err, 0);
        tick();
        m_if.bvalid[1] = 1'b0;
        neg(); chk("t4_err_set", err, 4'b0010);
        chk("t4_busy_zero", busy, 0);
        tick();
        m_if.bvalid[1] = 1'b1; m_if.bid[1] = 4'hA; b_q.push_back(mk_b(1, 4'hA, SLVERR));
        err_clr = 1'b1;
        tick();
        m_if.bvalid[1] = 1'b0; err_clr = 1'b0;
        neg(); chk("t4_set_wins", err, 4'b0010);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        neg(); chk("t4_err_cleared", err, 0);
        tick();

        // 5: AW and B handshakes in the same cycle on ch2
        s_if.awvalid[2] = 1'b1; s_if.awaddr[2] = 32'h500; aw_q.push_back(mk_a(2, 32'h500));
        tick();
        s_if.awaddr[2] = 32'h504; aw_q.push_back(mk_a(2, 32'h504));
        m_if.bvalid[2] = 1'b1; m_if.bid[2] = 4'h3; m_if.bresp[2] = OKAY;
        b_q.push_back(mk_b(2, 4'h3, OKAY));
        neg(); chk("t5_busy_pre", busy[2], 1);
        tick();
        s_if.awvalid[2] = 1'b0; m_if.bvalid[2] = 1'b0;
        neg(); chk("t5_busy_stays", busy[2], 1);
        tick();
        s_if.wvalid[2] = 1'b1; s_if.wlast[2] = 1'b1;
        tick(); tick();
        s_if.wvalid[2] = 1'b0; s_if.wlast[2] = 1'b0;
        m_if.bvalid[2] = 1'b1; m_if.bid[2] = 4'h4; b_q.push_back(mk_b(2, 4'h4, OKAY));
        tick();
        m_if.bvalid[2] = 1'b0;
        neg(); chk("t5_drained", busy, 0);
        chk("t5_no_err", err, 0);
        tick();

        // 6: reset mid-burst, then a fresh transaction
        m_if.rvalid[3] = 1'b1; m_if.rlast[3] = 1'b1;
        tick();
        m_if.rvalid[3] = 1'b0; m_if.rlast[3] = 1'b0;
        neg(); chk("t6_err_r_spur", err, 4'b1000);
        tick();
        s_if.awvalid[0] = 1'b1; s_if.awaddr[0] = 32'h600; aw_q.push_back(mk_a(0, 32'h600));
        tick();
        s_if.awvalid[0] = 1'b0; quiesce_req = 1'b1;
        neg(); chk("t6_busy_pre", busy, 4'b0001);
        tick();
        resetn = 1'b0;
        neg(); chk("t6_rst_ack", quiesce_ack, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_err", err, 0);
        quiesce_req = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        s_if.arvalid[0] = 1'b1; s_if.araddr[0] = 32'h700; ar_q.push_back(mk_a(0, 32'h700));
        neg(); chk("t6_fresh_ar", m_if.arvalid[0], 1);
        tick();
        s_if.arvalid[0] = 1'b0;
        neg(); chk("t6_fresh_busy", busy, 4'b0001);
        tick();
        m_if.rvalid[0] = 1'b1; m_if.rlast[0] = 1'b1;
        tick();
        m_if.rvalid[0] = 1'b0; m_if.rlast[0] = 1'b0;
        neg(); chk("t6_fresh_done", busy, 0);
        chk("t6_fresh_no_err", err, 0);
        chk("t6_fresh_ack", quiesce_ack, 0);
        tick();

        chk("aw_q_empty", 64'(aw_q.size()), 0);
        chk("ar_q_empty", 64'(ar_q.size()), 0);
        chk("b_q_empty", 64'(b_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
